// File: rtl/mixer_pkg.sv
// Shared types and helpers for the audio mixer: FSM states, pan encoding and
// accumulator sizing.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0] PAN_MUTE = 2'b00;
    localparam logic [1:0] PAN_L    = 2'b01;
    localparam logic [1:0] PAN_R    = 2'b10;
    localparam logic [1:0] PAN_LR   = 2'b11;

    // One guard bit per doubling of voices plus one spare, so a full-scale sum never wraps.
    function automatic int acc_width(input int voice_cnt, input int sample_width);
        return sample_width + $clog2(voice_cnt) + 1;
    endfunction

endpackage

// File: rtl/audio_mixer_voice_scaler.sv
// Volume scaling for one voice: signed sample times unsigned volume, floor-shifted
// back to sample width. Combinational; the mixer shares one instance across slots.
module voice_scaler #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int VOL_WIDTH    = 7
) (
    input  logic signed [SAMPLE_WIDTH-1:0] samp_i,
    input  logic        [VOL_WIDTH-1:0]    vol_i,
    output logic signed [SAMPLE_WIDTH-1:0] scaled_o
);

    logic signed [VOL_WIDTH:0]              vol_s;
    logic signed [SAMPLE_WIDTH+VOL_WIDTH-1:0] prod;
    logic                                   unused_lsbs;

    assign vol_s = $signed({1'b0, vol_i});
    assign prod  = samp_i * vol_s;

    // Gain is strictly below 1, so the shifted product always fits in the sample width.
    assign scaled_o    = prod[VOL_WIDTH +: SAMPLE_WIDTH];
    assign unused_lsbs = ^prod[VOL_WIDTH-1:0];

endmodule

// File: rtl/audio_mixer.sv
// Time-multiplexed stereo mixer: scales and pans VOICE_CNT voices one per cycle,
// saturates the sums and writes one {left,right} frame to the DAC FIFO.
module audio_mixer
    import mixer_pkg::*;
#(
    parameter int VOICE_CNT      = 4,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int VOL_WIDTH      = 7,
    parameter int CLIP_CNT_WIDTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              mix_ena_i,
    input  logic [VOICE_CNT*SAMPLE_WIDTH-1:0] voice_samp_i,
    input  logic [VOICE_CNT-1:0]              voice_val_i,
    output logic [VOICE_CNT-1:0]              voice_rd_o,
    input  logic [VOICE_CNT*VOL_WIDTH-1:0]    voice_vol_i,
    input  logic [VOICE_CNT*2-1:0]            voice_pan_i,
    input  logic                              dac_fifo_almfull_i,
    output logic [2*SAMPLE_WIDTH-1:0]         samp_data_o,
    output logic                              samp_wr_req_o,
    output logic                              underrun_o,
    input  logic                              clip_clr_i,
    output logic [CLIP_CNT_WIDTH-1:0]         clip_cnt_o
);

    localparam int SW    = SAMPLE_WIDTH;
    localparam int ACC_W = acc_width(VOICE_CNT, SAMPLE_WIDTH);
    localparam int IDX_W = (VOICE_CNT > 1) ? $clog2(VOICE_CNT) : 1;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(VOICE_CNT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = $signed({{(ACC_W-SW+1){1'b0}}, {(SW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN  = $signed({{(ACC_W-SW+1){1'b1}}, {(SW-1){1'b0}}});

    function automatic logic clips(input logic signed [ACC_W-1:0] a);
        return (a > SAT_MAX) || (a < SAT_MIN);
    endfunction

    function automatic logic signed [SW-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) return SAT_MAX[SW-1:0];
        if (a < SAT_MIN) return SAT_MIN[SW-1:0];
        return a[SW-1:0];
    endfunction

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic                        urun_flag_q, urun_flag_d;
    logic signed [SW-1:0]        lsat_q, lsat_d, rsat_q, rsat_d;
    logic [CLIP_CNT_WIDTH-1:0]   clip_cnt_q, clip_cnt_d;
    logic [2*SW-1:0]             samp_data_q, samp_data_d;
    logic                        wr_req_q, wr_req_d;
    logic                        underrun_q, underrun_d;

    logic signed [SW-1:0]        cur_samp, scaled;
    logic [VOL_WIDTH-1:0]        cur_vol;
    logic [1:0]                  cur_pan;
    logic                        cur_val;
    logic signed [ACC_W-1:0]     scaled_ext;
    logic                        take;

    assign cur_samp   = $signed(voice_samp_i[idx_q*SW +: SW]);
    assign cur_vol    = voice_vol_i[idx_q*VOL_WIDTH +: VOL_WIDTH];
    assign cur_pan    = voice_pan_i[idx_q*2 +: 2];
    assign cur_val    = voice_val_i[idx_q];
    assign scaled_ext = $signed({{(ACC_W-SW){scaled[SW-1]}}, scaled});
    assign take       = (state_q == ACCUM) && (cur_pan != PAN_MUTE) && cur_val;

    voice_scaler #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .VOL_WIDTH   (VOL_WIDTH)
    ) u_scaler (
        .samp_i  (cur_samp),
        .vol_i   (cur_vol),
        .scaled_o(scaled)
    );

    // The pop strobe must line up with the slot that consumes the sample.
    always_comb begin
        voice_rd_o = '0;
        if (take) voice_rd_o[idx_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        urun_flag_d = urun_flag_q;
        lsat_d      = lsat_q;
        rsat_d      = rsat_q;
        clip_cnt_d  = clip_cnt_q;
        samp_data_d = samp_data_q;
        wr_req_d    = 1'b0;
        underrun_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mix_ena_i && !dac_fifo_almfull_i) begin
                    state_d     = ACCUM;
                    idx_d       = '0;
                    acc_l_d     = '0;
                    acc_r_d     = '0;
                    urun_flag_d = 1'b0;
                end
            end
            ACCUM: begin
                if (cur_pan != PAN_MUTE) begin
                    if (cur_val) begin
                        if (cur_pan[0]) acc_l_d = acc_l_q + scaled_ext;
                        if (cur_pan[1]) acc_r_d = acc_r_q + scaled_ext;
                    end else begin
                        urun_flag_d = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SAT: begin
                lsat_d = sat_fn(acc_l_q);
                rsat_d = sat_fn(acc_r_q);
                if ((clips(acc_l_q) || clips(acc_r_q)) && (clip_cnt_q != '1))
                    clip_cnt_d = clip_cnt_q + 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                samp_data_d = {lsat_q, rsat_q};
                wr_req_d    = 1'b1;
                underrun_d  = urun_flag_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clip_clr_i) clip_cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            urun_flag_q <= 1'b0;
            lsat_q      <= '0;
            rsat_q      <= '0;
            clip_cnt_q  <= '0;
            samp_data_q <= '0;
            wr_req_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            urun_flag_q <= urun_flag_d;
            lsat_q      <= lsat_d;
            rsat_q      <= rsat_d;
            clip_cnt_q  <= clip_cnt_d;
            samp_data_q <= samp_data_d;
            wr_req_q    <= wr_req_d;
            underrun_q  <= underrun_d;
        end
    end

    assign samp_data_o   = samp_data_q;
    assign samp_wr_req_o = wr_req_q;
    assign underrun_o    = underrun_q;
    assign clip_cnt_o    = clip_cnt_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer with hand-computed frame values.
module tb_audio_mixer;

    localparam int VC = 4;
    localparam int SW = 16;
    localparam int VW = 7;
    localparam int CW = 8;

    logic               clk_i = 1'b0;
    logic               rst_n_i;
    logic               mix_ena_i;
    logic [VC*SW-1:0]   voice_samp_i;
    logic [VC-1:0]      voice_val_i;
    logic [VC-1:0]      voice_rd_o;
    logic [VC*VW-1:0]   voice_vol_i;
    logic [VC*2-1:0]    voice_pan_i;
    logic               dac_fifo_almfull_i;
    logic [2*SW-1:0]    samp_data_o;
    logic               samp_wr_req_o;
    logic               underrun_o;
    logic               clip_clr_i;
    logic [CW-1:0]      clip_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    audio_mixer #(
        .VOICE_CNT     (VC),
        .SAMPLE_WIDTH  (SW),
        .VOL_WIDTH     (VW),
        .CLIP_CNT_WIDTH(CW)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .mix_ena_i         (mix_ena_i),
        .voice_samp_i      (voice_samp_i),
        .voice_val_i       (voice_val_i),
        .voice_rd_o        (voice_rd_o),
        .voice_vol_i       (voice_vol_i),
        .voice_pan_i       (voice_pan_i),
        .dac_fifo_almfull_i(dac_fifo_almfull_i),
        .samp_data_o       (samp_data_o),
        .samp_wr_req_o     (samp_wr_req_o),
        .underrun_o        (underrun_o),
        .clip_clr_i        (clip_clr_i),
        .clip_cnt_o        (clip_cnt_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_voice(input int v, input int samp, input int vol,
                             input logic [1:0] pan, input logic val);
        voice_samp_i[v*SW +: SW] = samp[SW-1:0];
        voice_vol_i[v*VW +: VW]  = vol[VW-1:0];
        voice_pan_i[v*2 +: 2]    = pan;
        voice_val_i[v]           = val;
    endtask

    task automatic mute_all();
        for (int v = 0; v < VC; v++) set_voice(v, 0, 0, 2'b00, 1'b0);
    endtask

    // Starts a frame and watches it up to a bounded number of cycles.
    task automatic run_frame(input int almfull_at, input int drop_at,
                             output int lat, output logic [VC-1:0] rd_seen,
                             output int pops, output logic urun, output logic multi);
        mix_ena_i = 1'b1;
        lat = -1; rd_seen = '0; pops = 0; urun = 1'b0; multi = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_i); #1;
            if (i == almfull_at) dac_fifo_almfull_i = 1'b1;
            if (i == drop_at) mix_ena_i = 1'b0;
            rd_seen |= voice_rd_o;
            if (voice_rd_o != '0) pops++;
            if ($countones(voice_rd_o) > 1) multi = 1'b1;
            if (samp_wr_req_o) begin
                lat  = i - 1;
                urun = underrun_o;
                break;
            end
        end
    endtask

    task automatic count_writes(input int n, output int w);
        w = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            if (samp_wr_req_o) w++;
        end
    endtask

    int              lat, pops, w;
    logic [VC-1:0]   rd_seen;
    logic            urun, multi;

    initial begin
        rst_n_i = 1'b0; mix_ena_i = 1'b0; dac_fifo_almfull_i = 1'b0; clip_clr_i = 1'b0;
        voice_samp_i = '0; voice_val_i = '0; voice_vol_i = '0; voice_pan_i = '0;
        #22 rst_n_i = 1'b1;
        #1;
        check("rst_data",  int'(samp_data_o), 0);
        check("rst_wr",    int'(samp_wr_req_o), 0);
        check("rst_urun",  int'(underrun_o), 0);
        check("rst_clip",  int'(clip_cnt_o), 0);
        check("rst_rd",    int'(voice_rd_o), 0);

        // single voice at half gain into both channels
        mute_all();
        set_voice(0, 1000, 64, 2'b11, 1'b1);
        run_frame(-1, -1, lat, rd_seen, pops, urun, multi);
        mix_ena_i = 1'b0;
        check("t1_lat",  lat, 6);
        check("t1_rd",   int'(rd_seen), 1);
        check("t1_pops", pops, 1);
        check("t1_L",    int'($signed(samp_data_o[2*SW-1:SW])), 500);
        check("t1_R",    int'($signed(samp_data_o[SW-1:0])), 500);
        check("t1_urun", int'(urun), 0);
        check("t1_clip", int'(clip_cnt_o), 0);
        count_writes(3, w);
        check("t1_hold", int'($signed(samp_data_o[SW-1:0])), 500);

        // four full-scale negative voices clip
        for (int v = 0; v < VC; v++) set_voice(v, -32768, 127, 2'b11, 1'b1);
        run_frame(-1, -1, lat, rd_seen, pops, urun, multi);
        mix_ena_i = 1'b0;
        check("t2_lat",   lat, 6);
        check("t2_rd",    int'(rd_seen), 15);
        check("t2_pops",  pops, 4);
        check("t2_multi", int'(multi), 0);
        check("t2_L",     int'($signed(samp_data_o[2*SW-1:SW])), -32768);
        check("t2_R",     int'($signed(samp_data_o[SW-1:0])), -32768);
        check("t2_clip",  int'(clip_cnt_o), 1);
        clip_clr_i = 1'b1;
        @(posedge clk_i); #1;
        clip_clr_i = 1'b0;
        check("t2_clr",   int'(clip_cnt_o), 0);

        // hard-panned voices with floor rounding
        mute_all();
        set_voice(0, 20000, 127, 2'b01, 1'b1);
        set_voice(1, -4000, 127, 2'b10, 1'b1);
        run_frame(-1, -1, lat, rd_seen, pops, urun, multi);
        mix_ena_i = 1'b0;
        check("t3_L",    int'($signed(samp_data_o[2*SW-1:SW])), 19843);
        check("t3_R",    int'($signed(samp_data_o[SW-1:0])), -3969);
        check("t3_rd",   int'(rd_seen), 3);
        check("t3_clip", int'(clip_cnt_o), 0);

        // invalid active voice raises underrun; muted valid voice is ignored
        mute_all();
        set_voice(2, 1000, 64, 2'b01, 1'b0);
        set_voice(3, 1000, 64, 2'b00, 1'b1);
        run_frame(-1, -1, lat, rd_seen, pops, urun, multi);
        mix_ena_i = 1'b0;
        check("t4_lat",  lat, 6);
        check("t4_urun", int'(urun), 1);
        check("t4_rd",   int'(rd_seen), 0);
        check("t4_L",    int'($signed(samp_data_o[2*SW-1:SW])), 0);
        check("t4_R",    int'($signed(samp_data_o[SW-1:0])), 0);
        @(posedge clk_i); #1;
        check("t4_upulse", int'(underrun_o), 0);
        set_voice(2, 0, 0, 2'b00, 1'b0);
        run_frame(-1, -1, lat, rd_seen, pops, urun, multi);
        mix_ena_i = 1'b0;
        check("t4b_urun", int'(urun), 0);
        check("t4b_rd",   int'(rd_seen), 0);

        // almost-full held in IDLE blocks frames
        set_voice(0, 1000, 64, 2'b11, 1'b1);
        dac_fifo_almfull_i = 1'b1;
        mix_ena_i = 1'b1;
        count_writes(20, w);
        check("t5_block", w, 0);
        check("t5_rd",    int'(voice_rd_o), 0);
        mix_ena_i = 1'b0;
        dac_fifo_almfull_i = 1'b0;

        // almost-full raised mid-frame: frame completes, then waits
        run_frame(3, -1, lat, rd_seen, pops, urun, multi);
        check("t6_lat", lat, 6);
        check("t6_L",   int'($signed(samp_data_o[2*SW-1:SW])), 500);
        count_writes(15, w);
        check("t6_wait", w, 0);
        mix_ena_i = 1'b0;
        dac_fifo_almfull_i = 1'b0;

        // enable dropped during slot 1: one write, nothing after
        set_voice(0, -1000, 64, 2'b11, 1'b1);
        run_frame(-1, 2, lat, rd_seen, pops, urun, multi);
        check("t7_lat", lat, 6);
        check("t7_R",   int'($signed(samp_data_o[SW-1:0])), -500);
        count_writes(15, w);
        check("t7_none", w, 0);

        // reset during ACCUM after a clipping frame
        for (int v = 0; v < VC; v++) set_voice(v, 32767, 127, 2'b11, 1'b1);
        run_frame(-1, -1, lat, rd_seen, pops, urun, multi);
        mix_ena_i = 1'b0;
        check("t8_L",    int'($signed(samp_data_o[2*SW-1:SW])), 32767);
        check("t8_clip", int'(clip_cnt_o), 1);
        mix_ena_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        mix_ena_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        check("t8_data", int'(samp_data_o), 0);
        check("t8_wr",   int'(samp_wr_req_o), 0);
        check("t8_clr",  int'(clip_cnt_o), 0);
        check("t8_rd",   int'(voice_rd_o), 0);
        check("t8_urun", int'(underrun_o), 0);
        #2 rst_n_i = 1'b1;
        count_writes(12, w);
        check("t8_nowr", w, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
